// File: rtl/instr_perf_counters.sv
// -----------------------------------------------------------------------------
// instr_perf_counters
//
// Retired-instruction performance counters with a snapshot bank.
//
// Twelve live counters track elapsed cycles, non-NOP retired instructions and
// one count per instruction class decoded from the retiring encoding. A snap
// pulse copies the live bank into a snapshot bank. All software-visible reads
// come from the snapshot bank, so a consistent set of values can be read out
// over many cycles while the live bank keeps running. Pulsing snap and clr
// together gives read-and-clear behaviour.
//
// Parameters
//   CNT_W        width of every counter (8..64)
//   SATURATE     1: counters hold at all-ones, 0: counters wrap to zero
//   CYCLE_LIMIT  freeze counting once CYCLE reaches this value (0 = no limit)
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active low
//   retire_valid  one instruction retires this cycle
//   retire_instr  encoding of the retiring instruction
//   cnt_en        counting enable
//   clr           clear live counters, ovf and limit_hit
//   snap          copy live counters into the snapshot bank
//   rd_en         read request for snapshot[rd_addr]
//   rd_addr       counter index to read (12..15 read as zero)
//   rd_data       registered snapshot read data
//   rd_valid      rd_data carries the result of last cycle's read
//   ovf           sticky overflow flag per counter index
//   limit_hit     sticky flag: CYCLE_LIMIT has been reached
// -----------------------------------------------------------------------------
module instr_perf_counters #(
   parameter int unsigned      CNT_W       = 32,
   parameter bit               SATURATE    = 1'b1,
   parameter longint unsigned  CYCLE_LIMIT = 64'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             retire_valid,
   input  logic [31:0]      retire_instr,
   input  logic             cnt_en,
   input  logic             clr,
   input  logic             snap,
   input  logic             rd_en,
   input  logic [3:0]       rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_valid,
   output logic [11:0]      ovf,
   output logic             limit_hit
);

   localparam int unsigned NUM_CNT = 12;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(CYCLE_LIMIT);
   localparam bit               LIMIT_EN  = (CYCLE_LIMIT != 64'd0);

   // Counter index map; also the encoding of the decoded instruction class.
   typedef enum logic [3:0] {
      IDX_CYCLE  = 4'd0,
      IDX_TOTAL  = 4'd1,
      IDX_LD     = 4'd2,
      IDX_SD     = 4'd3,
      IDX_ADD    = 4'd4,
      IDX_SUB    = 4'd5,
      IDX_AND    = 4'd6,
      IDX_OR     = 4'd7,
      IDX_BRANCH = 4'd8,
      IDX_OPIMM  = 4'd9,
      IDX_NOP    = 4'd10,
      IDX_OTHER  = 4'd11
   } cnt_idx_e;

   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_REG    = 7'b0110011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [31:0] NOP_ENC   = 32'h0000_0013;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q  [NUM_CNT];
   logic [CNT_W-1:0] snap_q [NUM_CNT];
   logic [11:0]      ovf_q;
   logic             limit_q;
   logic [CNT_W-1:0] rd_data_q;
   logic             rd_valid_q;

   // ---------------------------------------------------------------------------
   // Instruction class decode
   // ---------------------------------------------------------------------------
   cnt_idx_e   instr_cls;
   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = retire_instr[6:0];
   assign funct3 = retire_instr[14:12];

   // NOTE: every signal written in an always_comb gets a default on entry, so
   // no path through the case statements can leave it unassigned (no latch).
   always_comb begin
      instr_cls = IDX_OTHER;
      case (opcode)
         OP_LOAD:   instr_cls = IDX_LD;
         OP_STORE:  instr_cls = IDX_SD;
         OP_REG: begin
            case (funct3)
               3'b000:  instr_cls = retire_instr[30] ? IDX_SUB : IDX_ADD;
               3'b111:  instr_cls = IDX_AND;
               3'b110:  instr_cls = IDX_OR;
               default: instr_cls = IDX_OTHER;
            endcase
         end
         OP_BRANCH: instr_cls = IDX_BRANCH;
         // The canonical NOP is an ADDI and must be split out of OPIMM.
         OP_IMM:    instr_cls = (retire_instr == NOP_ENC) ? IDX_NOP : IDX_OPIMM;
         default:   instr_cls = IDX_OTHER;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Increment requests and next counter values
   // ---------------------------------------------------------------------------
   logic             count_active;
   logic [11:0]      inc_req;
   logic [CNT_W-1:0] cnt_nxt [NUM_CNT];
   logic [11:0]      ovf_set;
   logic             limit_set;

   // Reset is handled in the register process; here only enable and the
   // frozen-by-limit condition gate counting.
   assign count_active = cnt_en && !limit_q;

   always_comb begin
      inc_req            = '0;
      inc_req[IDX_CYCLE] = 1'b1;
      if (retire_valid) begin
         inc_req[instr_cls] = 1'b1;
         inc_req[IDX_TOTAL] = (instr_cls != IDX_NOP);
      end
   end

   always_comb begin
      ovf_set = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_nxt[i] = cnt_q[i];
         if (count_active && inc_req[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               cnt_nxt[i] = SATURATE ? CNT_MAX : '0;
               ovf_set[i] = 1'b1;
            end else begin
               cnt_nxt[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // The flag rises on the same edge that moves CYCLE onto the limit value.
   assign limit_set = LIMIT_EN && count_active && (cnt_nxt[IDX_CYCLE] == LIMIT_VAL);

   // ---------------------------------------------------------------------------
   // Snapshot read mux; indices past the last counter read as zero
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (rd_addr == 4'(i)) begin
            rd_mux = snap_q[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; this is what lets snap capture the counters as
   // they stood before this cycle's increment or clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: the snapshot bank is a small flop array that software may read
         // straight after reset, so it is reset like any other register rather
         // than left undefined as a RAM would be.
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
         ovf_q      <= '0;
         limit_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (snap) begin
            for (int i = 0; i < NUM_CNT; i++) begin
               snap_q[i] <= cnt_q[i];
            end
         end

         if (clr) begin
            for (int i = 0; i < NUM_CNT; i++) begin
               cnt_q[i] <= '0;
            end
            ovf_q   <= '0;
            limit_q <= 1'b0;
         end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
               cnt_q[i] <= cnt_nxt[i];
            end
            ovf_q   <= ovf_q | ovf_set;
            limit_q <= limit_q | limit_set;
         end

         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_data_q <= rd_mux;
         end
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign ovf       = ovf_q;
   assign limit_hit = limit_q;

endmodule

// File: doc/instr_perf_counters.md
INSTR_PERF_COUNTERS -- requirements
Module: instr_perf_counters

Interface
REQ-001 Parameter CNT_W, 32, width of every counter (legal 8..64).
REQ-002 Parameter SATURATE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0.
REQ-003 Parameter CYCLE_LIMIT, 0, stops counting when the CYCLE counter reaches this value; 0 disables the limit.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 retire_valid  input  1  one instruction retires this cycle.
REQ-007 retire_instr  input  32  encoding of the retiring instruction.
REQ-008 cnt_en  input  1  counting enable.
REQ-009 clr  input  1  synchronous clear of the live counters, ovf and limit_hit.
REQ-010 snap  input  1  copies the live counters into the snapshot bank.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_addr  input  4  counter index to read.
REQ-013 rd_data  output  CNT_W  registered snapshot read data.
REQ-014 rd_valid  output  1  rd_data is valid this cycle.
REQ-015 ovf  output  12  sticky overflow flag, one bit per counter index.
REQ-016 limit_hit  output  1  sticky flag: CYCLE_LIMIT has been reached.

Function
REQ-017 Counter indices: 0 CYCLE, 1 TOTAL, 2 LD, 3 SD, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 BRANCH, 9 OPIMM, 10 NOP, 11 OTHER.
REQ-018 Decode of retire_instr:
- opcode 0000011 -> LD.
- opcode 0100011 -> SD.
- opcode 0110011 with funct3 000 -> SUB if bit30 = 1, else ADD.
- opcode 0110011 with funct3 111 -> AND; funct3 110 -> OR; any other funct3 -> OTHER.
- opcode 1100011 -> BRANCH.
- instr == 0x00000013 -> NOP.
- any other opcode 0010011 -> OPIMM.
- everything else -> OTHER.
REQ-019 Counting is active when rst = 1, cnt_en = 1 and limit_hit = 0.
REQ-020 While counting is active, CYCLE increments by 1 every cycle.
REQ-021 While counting is active and retire_valid = 1, exactly one class counter (indices 2-11) increments.
REQ-022 While counting is active and retire_valid = 1, TOTAL increments for every class except NOP.
REQ-023 Increment of a counter already at all-ones: hold at max if SATURATE = 1, wrap to 0 if SATURATE = 0; in both cases set the matching ovf bit.
REQ-024 ovf bits stay set until clr or reset.
REQ-025 When CYCLE_LIMIT != 0 and CYCLE becomes CYCLE_LIMIT on an edge, limit_hit is set on that same edge.
REQ-026 Once limit_hit = 1, all live counters freeze.
REQ-027 clr has priority over counting: on the next edge all live counters, ovf and limit_hit become 0, and the clr cycle itself is not counted.
REQ-028 clr does not alter the snapshot bank.
REQ-029 snap captures live counter values as held before the edge, i.e. excluding that cycle's increments.
REQ-030 snap and clr in the same cycle: the snapshot receives the pre-clear values (read-and-clear).
REQ-031 rd_en at edge N: rd_data = snapshot[rd_addr] and rd_valid = 1 after edge N, for one cycle (1-cycle latency).
REQ-032 rd_data holds its last value while rd_en = 0; rd_valid = 0 while rd_en = 0.
REQ-033 rd_addr 12-15 returns 0.
REQ-034 Reads use the snapshot bank only, never the live counters.

Reset
REQ-035 rst = 0 at an edge forces all live counters, snapshot bank, ovf, limit_hit, rd_data and rd_valid to 0.
REQ-036 Reset overrides clr, snap, rd_en and counting, including when asserted mid-operation.
REQ-037 Counting resumes on the first edge with rst = 1 and cnt_en = 1.

Verification
REQ-038 Defaults, cnt_en = 1 for 10 cycles retiring 00003083, 00103023, 002081B3, 402081B3, 0020F1B3, 0020E1B3, 00000063, 00100093, 00000013, 0000006F; then cnt_en = 0, snap, read indices 0-11 -> CYCLE 10, TOTAL 9, every class 1, ovf 0.
REQ-039 CNT_W = 8, 300 retired ADDs -> SATURATE = 1: ADD 255, ovf[4] = 1; SATURATE = 0: ADD 44, ovf[4] = 1.
REQ-040 CYCLE_LIMIT = 200, continuous retires -> limit_hit = 1 with CYCLE = 200; further cycles leave all counters unchanged; clr -> limit_hit 0 and counting restarts from 0.
REQ-041 5 ADDs, then snap and clr together, then 3 ADDs and snap -> reads of index 4 give 5 after the first snap and 3 after the second.
REQ-042 rst = 0 during active counting with rd_en = 1 -> next edge: all counters, snapshot, ovf, rd_data and rd_valid are 0.
REQ-043 rd_en pulse with rd_addr = 13 -> rd_valid = 1 for exactly one cycle with rd_data = 0.
